// File: rtl/life_stepper.sv
// Game of Life map register: steps one cell per clock into a shadow buffer, then commits atomically.
// Build option LIFE_TORUS_EN selects wrap-around edges; without it the map has a fixed dead border.
module life_stepper #(
   parameter int unsigned map_width  = 8,
   parameter int unsigned map_height = 8,
   parameter int unsigned gen_width  = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            load,
   input  logic [map_width*map_height-1:0] seed_in,
   input  logic                            step,
   output logic [map_width*map_height-1:0] state_out,
   output logic                            busy,
   output logic                            done,
   output logic                            stable,
   output logic                            extinct,
   output logic [gen_width-1:0]            generation
);

   localparam int unsigned CELLS = map_width * map_height;
   localparam int unsigned IDX_W = $clog2(CELLS);
   localparam int unsigned ROW_W = $clog2(map_height);
   localparam int unsigned COL_W = $clog2(map_width);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(map_width - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           fsm;
   logic [CELLS-1:0] shadow;
   logic [IDX_W-1:0] idx;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;

   logic [3:0]       nbr_cnt;
   logic             cell_alive;
   logic             cell_next;
   int               nr;
   int               nc;

   // Live-neighbour count for the cell at (row, col), read from the committed map.
   always_comb begin
      nbr_cnt = '0;
      nr      = 0;
      nc      = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
               nr = int'(row) + dr;
               nc = int'(col) + dc;
`ifdef LIFE_TORUS_EN
               if (nr < 0)
                  nr = int'(map_height) - 1;
               else if (nr >= int'(map_height))
                  nr = 0;
               if (nc < 0)
                  nc = int'(map_width) - 1;
               else if (nc >= int'(map_width))
                  nc = 0;
               nbr_cnt = nbr_cnt + 4'(state_out[IDX_W'(nr * int'(map_width) + nc)]);
`else
               if (nr >= 0 && nr < int'(map_height) && nc >= 0 && nc < int'(map_width))
                  nbr_cnt = nbr_cnt + 4'(state_out[IDX_W'(nr * int'(map_width) + nc)]);
`endif
            end
         end
      end
   end

   assign cell_alive = state_out[idx];
   assign cell_next  = (nbr_cnt == 4'd3) | (cell_alive & (nbr_cnt == 4'd2));

   // Sequencer: load/step accepted only in IDLE; CALC walks every cell; COMMIT publishes the shadow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm        <= IDLE;
         state_out  <= '0;
         shadow     <= '0;
         idx        <= '0;
         row        <= '0;
         col        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         stable     <= 1'b0;
         extinct    <= 1'b1;
         generation <= '0;
      end else begin
         done <= 1'b0;
         unique case (fsm)
            IDLE: begin
               if (load) begin
                  state_out  <= seed_in;
                  generation <= '0;
                  stable     <= 1'b0;
                  extinct    <= (seed_in == '0);
               end else if (step) begin
                  fsm  <= CALC;
                  busy <= 1'b1;
                  idx  <= '0;
                  row  <= '0;
                  col  <= '0;
               end
            end
            CALC: begin
               shadow[idx] <= cell_next;
               if (idx == IDX_LAST) begin
                  fsm <= COMMIT;
               end else begin
                  idx <= idx + IDX_W'(1);
                  if (col == COL_LAST) begin
                     col <= '0;
                     row <= row + ROW_W'(1);
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end
            COMMIT: begin
               state_out  <= shadow;
               stable     <= (shadow == state_out);
               extinct    <= (shadow == '0);
               generation <= generation + gen_width'(1);
               done       <= 1'b1;
               busy       <= 1'b0;
               fsm        <= IDLE;
            end
            default: begin
               fsm  <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_life_stepper.sv
// Scoreboard bench for life_stepper: stimulus pushes expected commits, a monitor checks each done pulse.
module tb_life_stepper;

   localparam int unsigned W  = 8;
   localparam int unsigned H  = 8;
   localparam int unsigned N  = W * H;
   localparam int unsigned GW = 16;

   localparam logic [N-1:0] BLINK_H = 64'h0000_0000_1C00_0000;
   localparam logic [N-1:0] BLINK_V = 64'h0000_0008_0808_0000;
   localparam logic [N-1:0] BLOCK   = 64'h0000_0000_0000_0303;
   localparam logic [N-1:0] SINGLE  = 64'h0000_0000_0800_0000;
   localparam logic [N-1:0] CORNER3 = 64'h0100_0000_0000_0081;
   localparam logic [N-1:0] CORNER4 = 64'h8100_0000_0000_0081;

   logic          clock;
   logic          reset;
   logic          load;
   logic [N-1:0]  seed_in;
   logic          step;
   logic [N-1:0]  state_out;
   logic          busy;
   logic          done;
   logic          stable;
   logic          extinct;
   logic [GW-1:0] generation;

   typedef struct {
      logic [N-1:0]  state;
      logic          stb;
      logic          ext;
      logic [GW-1:0] gen;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   t;

   life_stepper #(
      .map_width (W),
      .map_height(H),
      .gen_width (GW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .seed_in   (seed_in),
      .step      (step),
      .state_out (state_out),
      .busy      (busy),
      .done      (done),
      .stable    (stable),
      .extinct   (extinct),
      .generation(generation)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
   always @(negedge clock) begin
      exp_t e;
      if (reset && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=1 with no commit expected (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            check("commit_state",   64'(state_out),  64'(e.state));
            check("commit_stable",  64'(stable),     64'(e.stb));
            check("commit_extinct", 64'(extinct),    64'(e.ext));
            check("commit_gen",     64'(generation), 64'(e.gen));
            check("commit_cycle",   64'(cyc),        64'(e.cyc));
         end
      end
   end

   task automatic load_seed(input logic [N-1:0] s);
      @(negedge clock);
      load    = 1'b1;
      seed_in = s;
      @(negedge clock);
      load    = 1'b0;
      check("load_state",   64'(state_out),  64'(s));
      check("load_extinct", 64'(extinct),    64'(s == '0));
      check("load_gen",     64'(generation), 64'd0);
      check("load_stable",  64'(stable),     64'd0);
   endtask

   task automatic step_gen(input logic [N-1:0] st, input logic stb, input logic ext,
                           input logic [GW-1:0] g);
      int   ta;
      int   nbusy;
      exp_t e;
      @(negedge clock);
      step = 1'b1;
      @(posedge clock);
      #1;
      ta = cyc;
      e  = '{st, stb, ext, g, ta + int'(N) + 1};
      sb.push_back(e);
      nbusy = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clock);
         if (i == 0) step = 1'b0;
         if (busy) nbusy++;
      end
      check("busy_len",  64'(nbusy),     64'(N + 1));
      check("done_seen", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      load    = 1'b0;
      step    = 1'b0;
      seed_in = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_state",   64'(state_out),  64'd0);
      check("rst_busy",    64'(busy),       64'd0);
      check("rst_done",    64'(done),       64'd0);
      check("rst_stable",  64'(stable),     64'd0);
      check("rst_extinct", 64'(extinct),    64'd1);
      check("rst_gen",     64'(generation), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // One generation, then reset in the middle of the next computation.
      load_seed(BLINK_H);
      step_gen(BLINK_V, 1'b0, 1'b0, 16'd1);
      @(negedge clock);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      repeat (20) @(negedge clock);
      check("midcalc_busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("arst_state",   64'(state_out),  64'd0);
      check("arst_busy",    64'(busy),       64'd0);
      check("arst_extinct", 64'(extinct),    64'd1);
      check("arst_gen",     64'(generation), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // Blinker oscillation.
      load_seed(BLINK_H);
      step_gen(BLINK_V, 1'b0, 1'b0, 16'd1);
      step_gen(BLINK_H, 1'b0, 1'b0, 16'd2);

      // Block still life at the top-left corner.
      load_seed(BLOCK);
      step_gen(BLOCK, 1'b1, 1'b0, 16'd1);

      // Lone cell dies.
      load_seed(SINGLE);
      step_gen('0, 1'b0, 1'b1, 16'd1);

      // Three corners: wrap-around births the fourth, dead border kills all.
      load_seed(CORNER3);
`ifdef LIFE_TORUS_EN
      step_gen(CORNER4, 1'b0, 1'b0, 16'd1);
      step_gen(CORNER4, 1'b1, 1'b0, 16'd2);
`else
      step_gen('0, 1'b0, 1'b1, 16'd1);
      step_gen('0, 1'b1, 1'b1, 16'd2);
`endif

      // load and step raised mid-computation must be ignored.
      load_seed(BLINK_H);
      @(negedge clock);
      step = 1'b1;
      @(posedge clock);
      #1;
      t = cyc;
      sb.push_back('{BLINK_V, 1'b0, 1'b0, 16'd1, t + int'(N) + 1});
      @(negedge clock);
      step = 1'b0;
      repeat (10) @(negedge clock);
      load    = 1'b1;
      step    = 1'b1;
      seed_in = '1;
      repeat (10) @(negedge clock);
      load    = 1'b0;
      step    = 1'b0;
      seed_in = '0;
      repeat (60) @(negedge clock);
      check("ign_gen",   64'(generation), 64'd1);
      check("ign_state", 64'(state_out),  64'(BLINK_V));
      check("ign_busy",  64'(busy),       64'd0);
      check("ign_sb",    64'(sb.size()),  64'd0);

      // Held step: back-to-back generations with one idle cycle between.
      load_seed(BLINK_H);
      @(negedge clock);
      step = 1'b1;
      @(posedge clock);
      #1;
      t = cyc;
      sb.push_back('{BLINK_V, 1'b0, 1'b0, 16'd1, t + 65});
      sb.push_back('{BLINK_H, 1'b0, 1'b0, 16'd2, t + 131});
      sb.push_back('{BLINK_V, 1'b0, 1'b0, 16'd3, t + 197});
      repeat (197) @(posedge clock);
      @(negedge clock);
      step = 1'b0;
      repeat (5) @(negedge clock);
      check("held_sb",    64'(sb.size()),  64'd0);
      check("held_gen",   64'(generation), 64'd3);
      check("held_busy",  64'(busy),       64'd0);
      check("held_state", 64'(state_out),  64'(BLINK_V));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
